cpu_mem_server: RTL

- Memory-side responder for the 16-bit course CPU: serves instruction fetches (en_fetch/pc) with instruction words, and data accesses (en_mar_pulse/en_ram/wen_ram/mdr_ctrl) with MAR-addressed RAM reads and writes.
- Holds a program memory loadable while in reset, plus a data RAM.
- Replaces the hand-driven instruction/ram_data stimulus around the CPU with a cycle-accurate request/acknowledge memory.

---
 rtl/cpu_mem_server.sv | 102 ++++++++++
 1 files changed

// File: rtl/cpu_mem_server.sv
// cpu_mem_server: request/acknowledge instruction and data memory for the 16-bit course CPU.
// Program memory loads only while held in reset; data RAM is addressed through MAR.
module cpu_mem_server #(
  parameter int IMEM_AW = 8,
  parameter int DMEM_AW = 8,
  parameter int DW      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [IMEM_AW-1:0] prog_addr,
  input  logic [DW-1:0]      prog_data,
  input  logic               en_fetch,
  input  logic [DW-1:0]      pc_in,
  output logic [DW-1:0]      ins_out,
  output logic               ins_valid,
  input  logic               en_mar_pulse,
  input  logic [7:0]         offset_in,
  input  logic               en_ram,
  input  logic               wen_ram,
  input  logic [1:0]         mdr_ctrl,
  input  logic [DW-1:0]      wdata,
  output logic [DW-1:0]      ram_data,
  output logic               ram_ack,
  output logic [7:0]         mar_out,
  output logic               busy,
  output logic               err
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA, DONE} state_t;
  state_t               state_q;
  logic [DW-1:0]        imem [0:(1<<IMEM_AW)-1];
  logic [DW-1:0]        dmem [0:(1<<DMEM_AW)-1];
  logic [DW-1:0]        pc_q, wdata_q, ins_q, ram_data_q;
  logic [DMEM_AW-1:0]   addr_q, addr_d;
  logic [1:0]           ctrl_q;
  logic                 wen_q, ins_valid_q, ram_ack_q, err_q;
  logic [7:0]           mar_q;
  logic [DW-1:0]        rd_word, rd_lane_d, wr_word_d;
  logic                 pc_oob;
  // A MAR load in the same cycle as the request is bypassed into the access address
  assign addr_d    = en_mar_pulse ? offset_in[DMEM_AW-1:0] : mar_q[DMEM_AW-1:0];
  assign rd_word   = dmem[addr_q];
  assign rd_lane_d = ctrl_q == 2'b00 ? rd_word :
                     ctrl_q == 2'b01 ? {8'h00, rd_word[7:0]} :
                     ctrl_q == 2'b10 ? {8'h00, rd_word[15:8]} : '0;
  assign wr_word_d = ctrl_q == 2'b01 ? {rd_word[15:8], wdata_q[7:0]} :
                     ctrl_q == 2'b10 ? {wdata_q[7:0], rd_word[7:0]} : wdata_q;
  assign pc_oob    = (pc_q >> IMEM_AW) != '0;
  always_ff @(posedge clk) begin
    if (!rst && prog_we) imem[prog_addr] <= prog_data;
    if (rst && state_q == DATA && wen_q && ctrl_q != 2'b11) dmem[addr_q] <= wr_word_d;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      ram_data_q  <= '0;
      ram_ack_q   <= 1'b0;
      mar_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      ins_valid_q <= 1'b0;
      ram_ack_q   <= 1'b0;
      if (en_mar_pulse) mar_q <= offset_in;
      case (state_q)
        IDLE: begin
          if (en_ram) begin
            state_q <= DATA;
            addr_q  <= addr_d;
            wen_q   <= wen_ram;
            ctrl_q  <= mdr_ctrl;
            wdata_q <= wdata;
          end else if (en_fetch) begin
            state_q <= FETCH;
            pc_q    <= pc_in;
          end
        end
        FETCH: begin
          ins_q       <= pc_oob ? '0 : imem[pc_q[IMEM_AW-1:0]];
          ins_valid_q <= 1'b1;
          if (pc_oob) err_q <= 1'b1;
          state_q     <= DONE;
        end
        DATA: begin
          if (!wen_q) ram_data_q <= rd_lane_d;
          if (ctrl_q == 2'b11) err_q <= 1'b1;
          ram_ack_q <= 1'b1;
          state_q   <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign ins_out   = ins_q;
  assign ins_valid = ins_valid_q;
  assign ram_data  = ram_data_q;
  assign ram_ack   = ram_ack_q;
  assign mar_out   = mar_q;
  assign busy      = state_q != IDLE;
  assign err       = err_q;
endmodule
